lsu: RTL and testbench

Load/store stage of the in-order pipeline, directly upstream of the writeback stage. Registers one instruction from the execute stage through a valid/ready handshake. For loads and stores it runs a single request on a 64-bit data-memory port, aligns and extends load data, and presents the result to writeback with the same valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu.sv | 197 +++++++++++++++++++
 tb/tb_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store stage: registers one instruction from execute, performs at most one
// 64-bit data-memory access for loads/stores, and hands the result to writeback.

`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module lsu (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_pre_valid,
    output logic                   o_pre_ready,
    input  logic [`CPU_WIDTH-1:0]  i_exu_exres,
    input  logic [`CPU_WIDTH-1:0]  i_exu_rs2,
    input  logic [2:0]             i_exu_lsfunc,
    input  logic                   i_exu_lden,
    input  logic                   i_exu_sten,
    input  logic [`REG_ADDRW-1:0]  i_exu_rdid,
    input  logic                   i_exu_rdwen,
    input  logic [`CPU_WIDTH-1:0]  s_exu_diffpc,
    input  logic [`INS_WIDTH-1:0]  s_exu_ins,
    output logic                   o_mem_valid,
    input  logic                   i_mem_ready,
    output logic                   o_mem_wen,
    output logic [`CPU_WIDTH-1:0]  o_mem_addr,
    output logic [`CPU_WIDTH-1:0]  o_mem_wdata,
    output logic [7:0]             o_mem_wmask,
    input  logic [`CPU_WIDTH-1:0]  i_mem_rdata,
    output logic                   o_post_valid,
    input  logic                   i_post_ready,
    output logic [`CPU_WIDTH-1:0]  o_lsu_exres,
    output logic [`CPU_WIDTH-1:0]  o_lsu_lsres,
    output logic [`REG_ADDRW-1:0]  o_lsu_rdid,
    output logic                   o_lsu_rdwen,
    output logic                   o_lsu_lden,
    output logic [`CPU_WIDTH-1:0]  s_lsu_diffpc,
    output logic [`INS_WIDTH-1:0]  s_lsu_ins
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MEM   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Byte-enable pattern for the access size, shifted to the lane; overflow drops off.
    function automatic logic [7:0] store_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] ones;
        case (size)
            2'd0:    ones = 8'h01;
            2'd1:    ones = 8'h03;
            2'd2:    ones = 8'h0F;
            default: ones = 8'hFF;
        endcase
        return ones << off;
    endfunction

    function automatic logic [63:0] load_format(input logic [63:0] rdata,
                                                input logic [2:0]  func,
                                                input logic [2:0]  off);
        logic [63:0] sh;
        logic [63:0] res;
        sh = rdata >> {off, 3'b000};
        case (func)
            3'b000:  res = {{56{sh[7]}},  sh[7:0]};
            3'b001:  res = {{48{sh[15]}}, sh[15:0]};
            3'b010:  res = {{32{sh[31]}}, sh[31:0]};
            3'b100:  res = {56'd0, sh[7:0]};
            3'b101:  res = {48'd0, sh[15:0]};
            3'b110:  res = {32'd0, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_t                  state_q, state_d;
    logic [`CPU_WIDTH-1:0]   exres_q, rs2_q, lsres_q, lsres_d, diffpc_q;
    logic [2:0]              lsfunc_q;
    logic                    lden_q, sten_q, rdwen_q;
    logic [`REG_ADDRW-1:0]   rdid_q;
    logic [`INS_WIDTH-1:0]   ins_q;

    logic                    pre_ready_s, mem_valid_s, post_valid_s, capture_s;
    state_t                  accept_state_s;

    assign accept_state_s = (i_exu_lden | i_exu_sten) ? ST_MEM : ST_FULL;

    // Next-state and handshake decode.
    always_comb begin
        state_d      = state_q;
        pre_ready_s  = 1'b0;
        mem_valid_s  = 1'b0;
        post_valid_s = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                pre_ready_s = 1'b1;
                if (i_pre_valid) begin
                    state_d = accept_state_s;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_MEM: begin
                mem_valid_s = 1'b1;
                if (i_mem_ready) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_FULL: begin
                post_valid_s = 1'b1;
                pre_ready_s  = i_post_ready;
                if (i_post_ready && i_pre_valid) begin
                    state_d = accept_state_s;
                end else if (i_post_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    assign capture_s = i_pre_valid & pre_ready_s;

    // Load result: cleared on every capture so stores and ALU ops report zero.
    always_comb begin
        lsres_d = lsres_q;
        if (capture_s) begin
            lsres_d = {`CPU_WIDTH{1'b0}};
        end else if ((state_q == ST_MEM) && i_mem_ready && lden_q) begin
            lsres_d = load_format(i_mem_rdata, lsfunc_q, exres_q[2:0]);
        end else begin
            lsres_d = lsres_q;
        end
    end

    // State and payload registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_EMPTY;
            exres_q  <= {`CPU_WIDTH{1'b0}};
            rs2_q    <= {`CPU_WIDTH{1'b0}};
            lsres_q  <= {`CPU_WIDTH{1'b0}};
            diffpc_q <= {`CPU_WIDTH{1'b0}};
            lsfunc_q <= 3'd0;
            lden_q   <= 1'b0;
            sten_q   <= 1'b0;
            rdwen_q  <= 1'b0;
            rdid_q   <= {`REG_ADDRW{1'b0}};
            ins_q    <= {`INS_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            lsres_q <= lsres_d;
            if (capture_s) begin
                exres_q  <= i_exu_exres;
                rs2_q    <= i_exu_rs2;
                diffpc_q <= s_exu_diffpc;
                lsfunc_q <= i_exu_lsfunc;
                lden_q   <= i_exu_lden;
                sten_q   <= i_exu_sten;
                rdwen_q  <= i_exu_rdwen;
                rdid_q   <= i_exu_rdid;
                ins_q    <= s_exu_ins;
            end
        end
    end

    assign o_pre_ready  = pre_ready_s;
    assign o_mem_valid  = mem_valid_s;
    assign o_post_valid = post_valid_s;

    // Request fields come straight from the payload registers, so they stay stable in MEM.
    assign o_mem_wen   = mem_valid_s & sten_q;
    assign o_mem_addr  = {exres_q[`CPU_WIDTH-1:3], 3'b000};
    assign o_mem_wdata = rs2_q << {exres_q[2:0], 3'b000};
    assign o_mem_wmask = store_mask(lsfunc_q[1:0], exres_q[2:0]);

    assign o_lsu_exres  = exres_q;
    assign o_lsu_lsres  = lsres_q;
    assign o_lsu_rdid   = rdid_q;
    assign o_lsu_rdwen  = rdwen_q;
    assign o_lsu_lden   = lden_q;
    assign s_lsu_diffpc = diffpc_q;
    assign s_lsu_ins    = ins_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a table of single-instruction load/store/ALU vectors
// plus hand-written sequences for reset, back-to-back, delayed ready and backpressure.

module tb_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_pre_valid;
    logic        o_pre_ready;
    logic [63:0] i_exu_exres, i_exu_rs2;
    logic [2:0]  i_exu_lsfunc;
    logic        i_exu_lden, i_exu_sten;
    logic [4:0]  i_exu_rdid;
    logic        i_exu_rdwen;
    logic [63:0] s_exu_diffpc;
    logic [31:0] s_exu_ins;
    logic        o_mem_valid, i_mem_ready, o_mem_wen;
    logic [63:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [7:0]  o_mem_wmask;
    logic        o_post_valid, i_post_ready;
    logic [63:0] o_lsu_exres, o_lsu_lsres;
    logic [4:0]  o_lsu_rdid;
    logic        o_lsu_rdwen, o_lsu_lden;
    logic [63:0] s_lsu_diffpc;
    logic [31:0] s_lsu_ins;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    lsu dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
        .i_exu_exres(i_exu_exres), .i_exu_rs2(i_exu_rs2), .i_exu_lsfunc(i_exu_lsfunc),
        .i_exu_lden(i_exu_lden), .i_exu_sten(i_exu_sten),
        .i_exu_rdid(i_exu_rdid), .i_exu_rdwen(i_exu_rdwen),
        .s_exu_diffpc(s_exu_diffpc), .s_exu_ins(s_exu_ins),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_wen(o_mem_wen),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_rdata(i_mem_rdata),
        .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
        .o_lsu_exres(o_lsu_exres), .o_lsu_lsres(o_lsu_lsres),
        .o_lsu_rdid(o_lsu_rdid), .o_lsu_rdwen(o_lsu_rdwen), .o_lsu_lden(o_lsu_lden),
        .s_lsu_diffpc(s_lsu_diffpc), .s_lsu_ins(s_lsu_ins)
    );

    typedef struct {
        string       name;
        logic [63:0] exres;
        logic [63:0] rs2;
        logic [63:0] rdata;
        logic [2:0]  func;
        logic        ld;
        logic        st;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_mask;
        logic [63:0] e_lsres;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle 2ns after the rising edge.
    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        chk({v.name, ".pre_ready"}, {63'd0, o_pre_ready}, 64'd1);
        i_pre_valid  = 1'b1;
        i_exu_exres  = v.exres;
        i_exu_rs2    = v.rs2;
        i_exu_lsfunc = v.func;
        i_exu_lden   = v.ld;
        i_exu_sten   = v.st;
        i_exu_rdid   = idx[4:0];
        i_exu_rdwen  = ~v.st;
        step();
        i_pre_valid = 1'b0;
        if (v.ld || v.st) begin
            chk({v.name, ".mem_valid"}, {63'd0, o_mem_valid}, 64'd1);
            chk({v.name, ".addr"}, o_mem_addr, v.e_addr);
            chk({v.name, ".wen"}, {63'd0, o_mem_wen}, {63'd0, v.st});
            if (v.st) begin
                chk({v.name, ".wmask"}, {56'd0, o_mem_wmask}, {56'd0, v.e_mask});
                chk({v.name, ".wdata"}, o_mem_wdata, v.e_wdata);
            end
            chk({v.name, ".post_valid_mem"}, {63'd0, o_post_valid}, 64'd0);
            i_mem_ready = 1'b1;
            i_mem_rdata = v.rdata;
            step();
            i_mem_ready = 1'b0;
            i_mem_rdata = 64'd0;
        end
        chk({v.name, ".post_valid"}, {63'd0, o_post_valid}, 64'd1);
        chk({v.name, ".mem_valid_full"}, {63'd0, o_mem_valid}, 64'd0);
        chk({v.name, ".lsres"}, o_lsu_lsres, v.e_lsres);
        chk({v.name, ".exres"}, o_lsu_exres, v.exres);
        chk({v.name, ".lden"}, {63'd0, o_lsu_lden}, {63'd0, v.ld});
        chk({v.name, ".rdid"}, {59'd0, o_lsu_rdid}, {59'd0, idx[4:0]});
        step();
        chk({v.name, ".drained"}, {63'd0, o_post_valid}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{"LB",   64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 3'b000, 1'b1, 1'b0,
                     64'h8000_0000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1]  = '{"LBU",  64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 3'b100, 1'b1, 1'b0,
                     64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_0000_0080};
        vecs[2]  = '{"LH",   64'h0000_1002, 64'd0, 64'h1122_3344_F566_7788, 3'b001, 1'b1, 1'b0,
                     64'h0000_1000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_F566};
        vecs[3]  = '{"LHU",  64'h0000_1002, 64'd0, 64'h1122_3344_F566_7788, 3'b101, 1'b1, 1'b0,
                     64'h0000_1000, 64'd0, 8'h00, 64'h0000_0000_0000_F566};
        vecs[4]  = '{"LW",   64'h0000_200C, 64'd0, 64'h8765_4321_0000_0000, 3'b010, 1'b1, 1'b0,
                     64'h0000_2008, 64'd0, 8'h00, 64'hFFFF_FFFF_8765_4321};
        vecs[5]  = '{"LWU",  64'h0000_200C, 64'd0, 64'h8765_4321_0000_0000, 3'b110, 1'b1, 1'b0,
                     64'h0000_2008, 64'd0, 8'h00, 64'h0000_0000_8765_4321};
        vecs[6]  = '{"LD",   64'h0000_3000, 64'd0, 64'hDEAD_BEEF_0123_4567, 3'b011, 1'b1, 1'b0,
                     64'h0000_3000, 64'd0, 8'h00, 64'hDEAD_BEEF_0123_4567};
        vecs[7]  = '{"LDmis", 64'h0000_3001, 64'd0, 64'h1122_3344_5566_7788, 3'b011, 1'b1, 1'b0,
                     64'h0000_3000, 64'd0, 8'h00, 64'h0011_2233_4455_6677};
        vecs[8]  = '{"SB",   64'h0000_1005, 64'h0000_0000_0000_00AB, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0, 1'b1,
                     64'h0000_1000, 64'h0000_AB00_0000_0000, 8'h20, 64'd0};
        vecs[9]  = '{"SW",   64'h0000_2004, 64'h0000_0000_CAFE_BABE, 64'd0, 3'b010, 1'b0, 1'b1,
                     64'h0000_2000, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'd0};
        vecs[10] = '{"SWmis", 64'h0000_3006, 64'h0000_0000_1122_3344, 64'd0, 3'b010, 1'b0, 1'b1,
                     64'h0000_3000, 64'h3344_0000_0000_0000, 8'hC0, 64'd0};
        vecs[11] = '{"ALU",  64'hABCD_0000_1234_5677, 64'h5, 64'd0, 3'b011, 1'b0, 1'b0,
                     64'd0, 64'd0, 8'h00, 64'd0};

        i_rst_n = 1'b0; i_pre_valid = 1'b1; i_post_ready = 1'b1;
        i_exu_exres = 64'h99; i_exu_rs2 = 64'd0; i_exu_lsfunc = 3'd0;
        i_exu_lden = 1'b0; i_exu_sten = 1'b0; i_exu_rdid = 5'd3; i_exu_rdwen = 1'b1;
        s_exu_diffpc = 64'h8000_0000; s_exu_ins = 32'h13;
        i_mem_ready = 1'b0; i_mem_rdata = 64'd0;

        // Reset held for two cycles with a valid instruction offered.
        step(); step();
        chk("rst.pre_ready", {63'd0, o_pre_ready}, 64'd1);
        chk("rst.post_valid", {63'd0, o_post_valid}, 64'd0);
        chk("rst.mem_valid", {63'd0, o_mem_valid}, 64'd0);
        chk("rst.exres", o_lsu_exres, 64'd0);
        i_rst_n = 1'b1; i_pre_valid = 1'b0;
        step();

        // Three back-to-back ALU ops.
        i_pre_valid = 1'b1; i_exu_exres = 64'h11;
        step();
        chk("b2b.valid1", {63'd0, o_post_valid}, 64'd1);
        chk("b2b.exres1", o_lsu_exres, 64'h11);
        chk("b2b.pre_ready", {63'd0, o_pre_ready}, 64'd1);
        i_exu_exres = 64'h22;
        step();
        chk("b2b.valid2", {63'd0, o_post_valid}, 64'd1);
        chk("b2b.exres2", o_lsu_exres, 64'h22);
        chk("b2b.mem_valid", {63'd0, o_mem_valid}, 64'd0);
        i_exu_exres = 64'h33;
        step();
        chk("b2b.valid3", {63'd0, o_post_valid}, 64'd1);
        chk("b2b.exres3", o_lsu_exres, 64'h33);
        i_pre_valid = 1'b0;
        step();
        chk("b2b.empty", {63'd0, o_post_valid}, 64'd0);

        // Memory ready outside MEM must not advance anything.
        i_mem_ready = 1'b1;
        step();
        chk("ign.post_valid", {63'd0, o_post_valid}, 64'd0);
        chk("ign.mem_valid", {63'd0, o_mem_valid}, 64'd0);
        i_mem_ready = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(i);
        end

        // SH with memory ready delayed three cycles.
        i_pre_valid = 1'b1; i_exu_exres = 64'h8000_0006; i_exu_rs2 = 64'h1234;
        i_exu_lsfunc = 3'b001; i_exu_lden = 1'b0; i_exu_sten = 1'b1;
        step();
        i_pre_valid = 1'b0; i_exu_sten = 1'b0; i_exu_rs2 = 64'd0; i_exu_exres = 64'd0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                i_mem_ready = 1'b1;
                #1;
            end
            chk("sh.mem_valid", {63'd0, o_mem_valid}, 64'd1);
            chk("sh.addr", o_mem_addr, 64'h8000_0000);
            chk("sh.wdata", o_mem_wdata, 64'h1234_0000_0000_0000);
            chk("sh.wmask", {56'd0, o_mem_wmask}, 64'hC0);
            chk("sh.wen", {63'd0, o_mem_wen}, 64'd1);
            chk("sh.pre_ready", {63'd0, o_pre_ready}, 64'd0);
            chk("sh.post_valid", {63'd0, o_post_valid}, 64'd0);
            step();
        end
        i_mem_ready = 1'b0;
        chk("sh.post_rise", {63'd0, o_post_valid}, 64'd1);
        chk("sh.mem_drop", {63'd0, o_mem_valid}, 64'd0);
        chk("sh.lsres", o_lsu_lsres, 64'd0);
        step();

        // Backpressure: held for four cycles, then drain and accept together.
        i_pre_valid = 1'b1; i_exu_exres = 64'h55; i_exu_lsfunc = 3'd0;
        step();
        i_post_ready = 1'b0; i_exu_exres = 64'h66;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("bp.post_valid", {63'd0, o_post_valid}, 64'd1);
            chk("bp.exres_hold", o_lsu_exres, 64'h55);
            chk("bp.pre_ready", {63'd0, o_pre_ready}, 64'd0);
            step();
        end
        i_post_ready = 1'b1;
        #1;
        chk("bp.pre_ready_up", {63'd0, o_pre_ready}, 64'd1);
        step();
        chk("bp.new_exres", o_lsu_exres, 64'h66);
        chk("bp.new_valid", {63'd0, o_post_valid}, 64'd1);
        i_pre_valid = 1'b0;
        step();

        // Reset while a load waits in MEM.
        i_pre_valid = 1'b1; i_exu_exres = 64'h40; i_exu_lsfunc = 3'b011; i_exu_lden = 1'b1;
        step();
        i_pre_valid = 1'b0; i_exu_lden = 1'b0;
        chk("rmem.mem_valid", {63'd0, o_mem_valid}, 64'd1);
        i_rst_n = 1'b0;
        step();
        chk("rmem.mem_valid_off", {63'd0, o_mem_valid}, 64'd0);
        chk("rmem.post_valid", {63'd0, o_post_valid}, 64'd0);
        chk("rmem.pre_ready", {63'd0, o_pre_ready}, 64'd1);
        i_rst_n = 1'b1;
        step();
        chk("rmem.stay_empty", {63'd0, o_mem_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
